// File: rtl/booth_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_controller
// Description : Sequential radix-2 Booth multiplier controller that time-shares
//               one external adder/subtractor (signed WIDTH x WIDTH -> 2*WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 range_err,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_ITER  = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] C_MIN_M = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 q1_q, q1_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 range_err_q, range_err_d;
    logic                 range_pend_q, range_pend_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        q_d          = q_q;
        m_d          = m_q;
        q1_d         = q1_q;
        count_d      = count_q;
        product_d    = product_q;
        range_err_d  = range_err_q;
        range_pend_d = range_pend_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d          = multiplicand;
                    q_d          = multiplier;
                    a_d          = '0;
                    q1_d         = 1'b0;
                    count_d      = C_ITER;
                    range_pend_d = (multiplicand == C_MIN_M) && (multiplier != '0);
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                // 01 adds, 10 subtracts; add_cin already steers the adder.
                if (q_q[0] ^ q1_q) begin
                    a_d = add_sum;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {a_d, q_d, q1_d} = {a_q[WIDTH-1], a_q, q_q};
                count_d          = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    // Capture the post-shift result so it is valid alongside done.
                    product_d   = {a_q[WIDTH-1], a_q, q_q[WIDTH-1:1]};
                    range_err_d = range_pend_q;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            q_q          <= '0;
            m_q          <= '0;
            q1_q         <= 1'b0;
            count_q      <= '0;
            product_q    <= '0;
            range_err_q  <= 1'b0;
            range_pend_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            q_q          <= q_d;
            m_q          <= m_d;
            q1_q         <= q1_d;
            count_q      <= count_d;
            product_q    <= product_d;
            range_err_q  <= range_err_d;
            range_pend_q <= range_pend_d;
            done_q       <= done_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign product   = product_q;
    assign range_err = range_err_q;
    assign add_a     = a_q;
    assign add_b     = m_q;
    assign add_cin   = (state_q == S_EVAL) && q_q[0] && !q1_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_controller
// Description : Directed and random signed-multiply checks for the Booth
//               controller, with a behavioural adder/subtractor attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        range_err;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;

    int checks = 0;
    int errors = 0;

    booth_seq_controller #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .range_err    (range_err),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum)
    );

    assign add_sum = add_cin ? (add_a - add_b) : (add_a + add_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One multiply: accept, then walk the 17 following cycles checking
    // handshake, adder control and the result in the done cycle.
    task automatic run_job(input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] ep, input logic ee,
                           input bit chk_prod, input bit intrude);
        int   i;
        logic b0, b1;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 5) start = 1'b0;
            chk("ready_low", ready, 0);
            chk("done_timing", done, (n == 17));
            if (n % 2 == 1 && n < 17) begin
                i  = (n + 1) / 2;
                b0 = q[i-1];
                b1 = (i > 1) ? q[i-2] : 1'b0;
                chk("cin_eval", add_cin, (b0 && !b1));
            end else begin
                chk("cin_other", add_cin, 0);
            end
            if (n == 17) begin
                if (chk_prod) chk("product", product, ep);
                chk("range_err", range_err, ee);
            end
            if (intrude && (n == 4 || n == 17)) begin
                start        = 1'b1;
                multiplicand = 8'h11;
                multiplier   = 8'h22;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_ready", ready, 1);
        chk("idle_done", done, 0);
        if (chk_prod) chk("product_hold", product, ep);
        chk("range_hold", range_err, ee);
    endtask

    initial begin
        logic [7:0]         rm, rq;
        logic signed [15:0] sm, sq;
        logic [15:0]        rp;

        clk          = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_range", range_err, 0);
        chk("rst_cin", add_cin, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(8'h03, 8'h05, 16'h000F, 1'b0, 1'b1, 1'b0);
        run_job(8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b1, 1'b0);
        run_job(8'h05, 8'hFD, 16'hFFF1, 1'b0, 1'b1, 1'b0);
        run_job(8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        run_job(8'h7F, 8'h80, 16'hC080, 1'b0, 1'b1, 1'b0);
        run_job(8'h80, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_job(8'h80, 8'h03, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_job(8'h06, 8'hF9, 16'hFFD6, 1'b0, 1'b1, 1'b1);
        run_job(8'h00, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Abort in cycle 9 of a running job.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'h03;
        multiplier   = 8'h05;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_job(8'h07, 8'h09, 16'h003F, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            if (rm == 8'h80) rm = 8'h81;
            sm = 16'(signed'(rm));
            sq = 16'(signed'(rq));
            rp = 16'(sm * sq);
            run_job(rm, rq, rp, 1'b0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
